// File: rtl/spi_slave_regport.sv
// spi_slave_regport
//   SPI mode-0 slave exposed to Z80 software as two ZXUNO registers.
//   Bytes clocked in by an external master are queued in a small RX FIFO.
//   A single TX holding byte is returned on MISO.
//
// Ports
//   clk, rst_n           system clock, asynchronous active-low reset
//   addr, ior, iow, din  ZXUNO register bus (ior/iow are levels held per I/O cycle)
//   dout, oe_n           read data and its active-low valid strobe
//   spi_cs_n/sclk/mosi   external SPI inputs, asynchronous to clk
//   spi_miso             MISO back to the master (1 while idle)
//   irq_n                active-low interrupt
//
// Optional feature macro: SPI_SLAVE_IRQ_EN
//   When defined, irq_n is driven low (registered) while the RX FIFO holds data
//   or overrun is set. Otherwise irq_n is tied high.
module spi_slave_regport #(
  parameter logic [7:0] DATAREG = 8'hF8,
  parameter logic [7:0] STATREG = 8'hF9,
  parameter int         FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic       ior,
  input  logic       iow,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       irq_n
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cs_sync_q, cs_sync_d;
  logic [2:0]         sclk_sync_q, sclk_sync_d;
  logic [1:0]         mosi_sync_q, mosi_sync_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         rx_shift_q, rx_shift_d;
  logic [7:0]         tx_shift_q, tx_shift_d;
  logic               skip_fall_q, skip_fall_d;
  logic [7:0]         tx_hold_q, tx_hold_d;
  logic               tx_valid_q, tx_valid_d;
  logic               overrun_q, overrun_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               rd_sel_q, rd_sel_d;
  logic               wr_data_sel_q, wr_data_sel_d;
  logic               wr_stat_sel_q, wr_stat_sel_d;

  logic [7:0] fifo_mem [DEPTH];

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;
  logic rd_data_sel, rd_stat_sel, wr_data_sel, wr_stat_sel;
  logic wr_data, wr_stat, pop, push_req, push, tx_clear;
  logic fifo_full, fifo_empty;
  logic [7:0] tx_load, fifo_head, status;

  // Edge detection compares the last two synchroniser stages
  assign cs_fall   =  cs_sync_q[2]   & ~cs_sync_q[1];
  assign cs_rise   = ~cs_sync_q[2]   &  cs_sync_q[1];
  assign sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];
  assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];

  assign rd_data_sel = ior && (addr == DATAREG);
  assign rd_stat_sel = ior && (addr == STATREG);
  assign wr_data_sel = iow && (addr == DATAREG);
  assign wr_stat_sel = iow && (addr == STATREG);
  assign wr_data     = wr_data_sel && !wr_data_sel_q;
  assign wr_stat     = wr_stat_sel && !wr_stat_sel_q;

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  // Pop once per CPU read, when the read select drops
  assign pop        = rd_sel_q && !rd_data_sel && !fifo_empty;
  assign tx_load    = tx_valid_q ? tx_hold_q : 8'hFF;
  assign fifo_head  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign status     = {3'b000, ~cs_sync_q[1], overrun_q, tx_valid_q, fifo_full, ~fifo_empty};
  // A full FIFO still accepts a byte when a pop frees a slot in the same clk
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    cs_sync_d     = {cs_sync_q[1:0], spi_cs_n};
    sclk_sync_d   = {sclk_sync_q[1:0], spi_sclk};
    mosi_sync_d   = {mosi_sync_q[0], spi_mosi};
    rd_sel_d      = rd_data_sel;
    wr_data_sel_d = wr_data_sel;
    wr_stat_sel_d = wr_stat_sel;
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    skip_fall_d   = skip_fall_q;
    push_req      = 1'b0;
    tx_clear      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          bitcnt_d    = 3'd0;
          tx_shift_d  = tx_load;
          tx_clear    = 1'b1;
          skip_fall_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          bitcnt_d    = 3'd0;
          skip_fall_d = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bitcnt_d   = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            push_req    = 1'b1;
            tx_shift_d  = tx_load;
            tx_clear    = 1'b1;
            // MSB of the reloaded byte must survive the next falling edge
            skip_fall_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (skip_fall_q) begin
            skip_fall_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b1};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reload consumes the old holding byte; a same-clk write still lands afterwards
    tx_hold_d  = tx_hold_q;
    tx_valid_d = tx_valid_q;
    if (tx_clear) tx_valid_d = 1'b0;
    if (wr_data) begin
      tx_hold_d  = din;
      tx_valid_d = 1'b1;
    end

    overrun_d = overrun_q;
    if (wr_stat && din[3]) overrun_d = 1'b0;
    if (push_req && !push) overrun_d = 1'b1;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // cs_n stages start low so a master already holding cs_n low across
      // reset does not produce a false falling edge
      cs_sync_q     <= 3'b000;
      sclk_sync_q   <= 3'b000;
      mosi_sync_q   <= 2'b11;
      state_q       <= IDLE;
      bitcnt_q      <= 3'd0;
      rx_shift_q    <= 8'hFF;
      tx_shift_q    <= 8'hFF;
      skip_fall_q   <= 1'b0;
      tx_hold_q     <= 8'hFF;
      tx_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_sel_q      <= 1'b0;
      wr_data_sel_q <= 1'b0;
      wr_stat_sel_q <= 1'b0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      sclk_sync_q   <= sclk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      skip_fall_q   <= skip_fall_d;
      tx_hold_q     <= tx_hold_d;
      tx_valid_q    <= tx_valid_d;
      overrun_q     <= overrun_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rd_sel_q      <= rd_sel_d;
      wr_data_sel_q <= wr_data_sel_d;
      wr_stat_sel_q <= wr_stat_sel_d;
    end
  end

  // Storage needs no reset: count_q alone defines which entries are valid
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rx_shift_d;
  end

  assign spi_miso = (state_q == ACTIVE) ? tx_shift_q[7] : 1'b1;
  assign oe_n     = ~(rd_data_sel | rd_stat_sel);
  assign dout     = rd_data_sel ? fifo_head : (rd_stat_sel ? status : 8'h00);

`ifdef SPI_SLAVE_IRQ_EN
  logic irq_n_q, irq_n_d;
  assign irq_n_d = ~(~fifo_empty | overrun_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_n_q <= 1'b1;
    else        irq_n_q <= irq_n_d;
  end
  assign irq_n = irq_n_q;
`else
  assign irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_spi_slave_regport.sv
// tb_spi_slave_regport
//   Scoreboard bench for spi_slave_regport: a behavioural model of the RX
//   FIFO, overrun flag and TX holding byte queues expected RX bytes and
//   expected MISO bytes; DUT register reads and master transfers pop and
//   compare against them.
module tb_spi_slave_regport;

  localparam logic [7:0] DATAREG = 8'hF8;
  localparam logic [7:0] STATREG = 8'hF9;
  localparam int H = 6;  // clk cycles per SCLK half period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       ior = 1'b0;
  logic       iow = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       oe_n;
  logic       spi_cs_n = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b1;
  logic       spi_miso;
  logic       irq_n;

  int checks = 0;
  int failures = 0;

  // model state
  logic [7:0] m_fifo[$];
  logic [7:0] miso_q[$];
  logic       m_ovr = 1'b0;
  logic [7:0] m_txh = 8'hFF;
  logic       m_txv = 1'b0;
  logic       m_cs_active = 1'b0;

  spi_slave_regport #(.DATAREG(DATAREG), .STATREG(STATREG), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .ior(ior), .iow(iow), .din(din),
    .dout(dout), .oe_n(oe_n), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {3'b000, m_cs_active, m_ovr, m_txv, m_fifo.size() == 4, m_fifo.size() != 0};
  endfunction

  task automatic m_load();
    miso_q.push_back(m_txv ? m_txh : 8'hFF);
    m_txv = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    addr = a;
    ior = 1'b1;
    @(negedge clk);
    @(negedge clk);
    v = dout;
    check_val("oe_n_read", oe_n, 1'b0);
    ior = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    din = d;
    iow = 1'b1;
    @(negedge clk);
    @(negedge clk);
    iow = 1'b0;
    @(negedge clk);
    if (a == DATAREG) begin
      m_txh = d;
      m_txv = 1'b1;
    end else if (a == STATREG && d[3]) begin
      m_ovr = 1'b0;
    end
    $display("wr reg %h <= %h", a, d);
  endtask

  task automatic rd_data();
    logic [7:0] v, e;
    cpu_read(DATAREG, v);
    e = (m_fifo.size() != 0) ? m_fifo.pop_front() : 8'h00;
    $display("rd data %h (exp %h)", v, e);
    check_val("rx_data", v, e);
  endtask

  task automatic rd_stat(input string tag);
    logic [7:0] v;
    cpu_read(STATREG, v);
    $display("rd stat %h (exp %h)", v, exp_status());
    check_val(tag, v, exp_status());
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    m_cs_active = 1'b1;
    m_load();
    repeat (H) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    spi_cs_n = 1'b1;
    m_cs_active = 1'b0;
    miso_q.delete();
    repeat (H) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic mo);
    spi_mosi = b;
    repeat (H) @(negedge clk);
    mo = spi_miso;
    spi_sclk = 1'b1;
    repeat (H) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic byte_done(input logic [7:0] rx, input logic [7:0] got);
    logic [7:0] e;
    e = (miso_q.size() != 0) ? miso_q.pop_front() : 8'hXX;
    $display("spi byte mosi %h miso %h (exp %h)", rx, got, e);
    check_val("miso_byte", got, e);
    if (m_fifo.size() < 4) m_fifo.push_back(rx);
    else m_ovr = 1'b1;
    m_load();
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [7:0] got;
    for (int i = 7; i >= 0; i--) spi_bit(b[i], got[i]);
    byte_done(b, got);
  endtask

  initial begin
    logic [7:0] got, rdv, b5;
    logic mo;

    // reset state
    repeat (3) @(negedge clk);
    check_val("rst_miso", spi_miso, 1'b1);
    check_val("rst_dout", dout, 8'h00);
    check_val("rst_oe_n", oe_n, 1'b1);
    check_val("rst_irq_n", irq_n, 1'b1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd_stat("rst_status");

    // 1: single byte A5
    cs_low();
    spi_byte(8'hA5);
    cs_high();
`ifdef SPI_SLAVE_IRQ_EN
    check_val("irq_after_rx", irq_n, 1'b0);
`else
    check_val("irq_tied", irq_n, 1'b1);
`endif
    rd_stat("t1_stat_ne");
    rd_data();
    rd_stat("t1_stat_empty");
    check_val("irq_after_read", irq_n, 1'b1);

    // 2: TX holding byte, overwrite while valid, then 2-byte transfer
    cpu_write(DATAREG, 8'h55);
    cpu_write(DATAREG, 8'h3C);
    rd_stat("t2_txvalid");
    cs_low();
    rd_stat("t2_after_csfall");
    spi_byte(8'hA1);
    spi_byte(8'hB2);
    cs_high();
    rd_data();
    rd_data();

    // 3: overflow a depth-4 FIFO
    cs_low();
    for (int i = 1; i <= 5; i++) spi_byte(8'(i));
    cs_high();
    rd_stat("t3_full_ovr");
    for (int i = 0; i < 4; i++) rd_data();
    rd_stat("t3_ovr_only");
    cpu_write(STATREG, 8'hF7);
    rd_stat("t3_ovr_kept");
    cpu_write(STATREG, 8'h08);
    rd_stat("t3_ovr_clear");

    // 4: partial byte discarded
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b0, mo);
    cs_high();
    cs_low();
    spi_byte(8'h7E);
    cs_high();
    rd_stat("t4_one");
    rd_data();
    rd_data();  // empty read returns 00

    // 5: push onto full FIFO in the same clk as a pop
    cs_low();
    spi_byte(8'h11);
    spi_byte(8'h22);
    spi_byte(8'h33);
    spi_byte(8'h44);
    b5 = 8'h55;
    for (int i = 7; i >= 1; i--) spi_bit(b5[i], got[i]);
    @(negedge clk);
    addr = DATAREG;
    ior = 1'b1;
    spi_mosi = b5[0];
    repeat (H) @(negedge clk);
    rdv = dout;
    got[0] = spi_miso;
    spi_sclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ior = 1'b0;  // pop lands on the same clk the 8th rising edge is acted on
    repeat (H - 2) @(negedge clk);
    spi_sclk = 1'b0;
    $display("rd data %h during push (exp %h)", rdv, m_fifo[0]);
    check_val("t5_pop_head", rdv, m_fifo.pop_front());
    byte_done(b5, got);
    cs_high();
    rd_stat("t5_full_no_ovr");
    for (int i = 0; i < 4; i++) rd_data();

    // 6: reset mid-byte after causing an overrun
    cs_low();
    for (int i = 0; i < 5; i++) spi_byte(8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) spi_bit(1'b1, mo);
    @(negedge clk);
    rst_n = 1'b0;
    m_fifo.delete();
    miso_q.delete();
    m_ovr = 1'b0;
    m_txv = 1'b0;
    m_txh = 8'hFF;
    @(negedge clk);
    check_val("t6_miso_in_rst", spi_miso, 1'b1);
    rst_n = 1'b1;
    repeat (H) @(negedge clk);
    check_val("t6_miso_after_rst", spi_miso, 1'b1);
    rd_stat("t6_stat_cs_low");
    cs_high();
    rd_stat("t6_stat_idle");
    cs_low();
    spi_byte(8'hC3);
    cs_high();
    rd_data();
    rd_stat("t6_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
